// File: rtl/dpram_stream_pkg.sv
// rtl/dpram_stream_pkg.sv - shared defaults, FSM states and output FIFO depth for the RAM stream reader
package dpram_stream_pkg;

  localparam int AWIDTH_DEFAULT    = 12;
  localparam int DWIDTH_DEFAULT    = 60;
  localparam int NUM_WORDS_DEFAULT = 4096;
  localparam int FIFO_DEPTH        = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/dpram_rd_fifo.sv
// rtl/dpram_rd_fifo.sv - 3-entry shift-register FIFO whose head register is the stream output
module dpram_rd_fifo
  import dpram_stream_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              pop,
  output logic [DWIDTH-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [1:0]        occupancy
);

  logic [DWIDTH-1:0] mem [FIFO_DEPTH];
  logic [1:0]        occ;
  logic              do_push;
  logic              do_pop;
  logic [1:0]        wr_idx;

  assign do_pop  = pop && (occ != 2'd0);
  assign do_push = push && ((occ != 2'(FIFO_DEPTH)) || do_pop);
  // With a simultaneous pop the entries shift down, so the new word lands one slot lower
  assign wr_idx  = do_pop ? (occ - 2'd1) : occ;

  // Entry 0 is always the head; pops shift the queue toward it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      occ <= 2'd0;
    end else begin
      if (do_pop) begin
        for (int i = 0; i < FIFO_DEPTH - 1; i++) mem[i] <= mem[i+1];
      end
      if (do_push) mem[wr_idx] <= wdata;
      occ <= occ + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head      = mem[0];
  assign full      = (occ == 2'(FIFO_DEPTH));
  assign empty     = (occ == 2'd0);
  assign occupancy = occ;

endmodule

// File: rtl/dpram_stream_reader.sv
// rtl/dpram_stream_reader.sv - strided RAM read client with valid/ready output; DPRAM_STREAM_WRAP_EN selects address wrap over range abort
module dpram_stream_reader
  import dpram_stream_pkg::*;
#(
  parameter int AWIDTH    = AWIDTH_DEFAULT,
  parameter int NUM_WORDS = NUM_WORDS_DEFAULT,
  parameter int DWIDTH    = DWIDTH_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [AWIDTH:0]   count,
  input  logic [AWIDTH-1:0] stride,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [AWIDTH-1:0] ram_addr,
  output logic              ram_wren,
  output logic [DWIDTH-1:0] ram_wdata,
  input  logic [DWIDTH-1:0] ram_rdata,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic [AWIDTH:0] ADDR_LIMIT = (AWIDTH+1)'(NUM_WORDS);

  state_t            state;
  logic [AWIDTH:0]   remaining;
  logic [AWIDTH-1:0] stride_q;
  logic              inflight;
  logic              err_pend;
  logic [1:0]        occ;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              issue;
  logic              last_issue;
  logic              drain_done;
  logic [AWIDTH:0]   next_addr_full;
  logic              addr_past_end;
  logic [AWIDTH-1:0] next_addr;
  logic              addr_overflow;

  assign ram_wren  = 1'b0;
  assign ram_wdata = '0;

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  // ram_addr holds the address the RAM samples at the next edge, so an issue is that sampling edge.
  // Only registered terms gate it, keeping out_ready off the RAM address path.
  assign issue      = (state == RUN) && !fifo_full &&
                      (({1'b0, occ} + {2'b00, inflight}) < 3'(FIFO_DEPTH));
  assign last_issue = (remaining == {{AWIDTH{1'b0}}, 1'b1});

  assign next_addr_full = {1'b0, ram_addr} + {1'b0, stride_q};
  assign addr_past_end  = (next_addr_full >= ADDR_LIMIT);

`ifdef DPRAM_STREAM_WRAP_EN
  assign next_addr     = addr_past_end ? AWIDTH'(next_addr_full - ADDR_LIMIT)
                                       : next_addr_full[AWIDTH-1:0];
  assign addr_overflow = 1'b0;
`else
  assign next_addr     = next_addr_full[AWIDTH-1:0];
  assign addr_overflow = addr_past_end;
`endif

  // Finish in the cycle right after the final stream transfer, so a pop emptying the FIFO counts
  assign drain_done = (state == DRAIN) && !inflight &&
                      ((occ == 2'd0) || ((occ == 2'd1) && pop));

  // Request FSM: address generation, read tracking and done/err pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ram_addr  <= '0;
      remaining <= '0;
      stride_q  <= '0;
      inflight  <= 1'b0;
      err_pend  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      inflight <= issue;
      case (state)
        IDLE: begin
          if (start) begin
            if (count != '0) begin
              ram_addr  <= base_addr;
              remaining <= count;
              stride_q  <= stride;
              err_pend  <= 1'b0;
              busy      <= 1'b1;
              state     <= RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue) begin
            remaining <= remaining - 1'b1;
            if (last_issue) begin
              state <= DRAIN;
            end else if (addr_overflow) begin
              err_pend <= 1'b1;
              state    <= DRAIN;
            end else begin
              ram_addr <= next_addr;
            end
          end
        end
        DRAIN: begin
          if (drain_done) begin
            done  <= 1'b1;
            err   <= err_pend;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  dpram_rd_fifo #(
    .DWIDTH(DWIDTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (inflight),
    .wdata    (ram_rdata),
    .pop      (pop),
    .head     (out_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .occupancy(occ)
  );

endmodule

// File: tb/tb_dpram_stream_reader.sv
// tb/tb_dpram_stream_reader.sv - randomized bench for dpram_stream_reader against a word-list reference model
module tb_dpram_stream_reader;

  localparam int AW = 12;
  localparam int DW = 60;
  localparam int NW = 4096;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   count;
  logic [AW-1:0] stride;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] ram_addr;
  logic          ram_wren;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int ready_mode;
  bit poke;

  logic [DW-1:0] ram_mem [NW];

  logic [DW-1:0] got_q[$];
  logic [AW-1:0] addr_log[$];
  logic [AW-1:0] prev_addr = '0;
  int done_cnt, err_cnt, err_lone, done_cyc, first_valid;

  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_addrs[$];
  int exp_err;

  always #5 clk = ~clk;

  dpram_stream_reader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .base_addr(base_addr),
    .count    (count),
    .stride   (stride),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .ram_addr (ram_addr),
    .ram_wren (ram_wren),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // Synchronous-read RAM: data for the sampled address appears after the edge
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    ram_rdata <= ram_mem[ram_addr];
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  always @(posedge clk) begin
    #1;
    if (poke) begin
      start     = busy && ($urandom_range(0, 2) == 0);
      base_addr = AW'($urandom_range(0, NW - 1));
      count     = (AW+1)'($urandom_range(1, 20));
    end
  end

  always @(negedge clk) begin
    if (out_valid && out_ready) got_q.push_back(out_data);
    if (out_valid && first_valid < 0) first_valid = cyc;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (err) begin
      if (done) err_cnt++;
      else err_lone++;
    end
    if (ram_addr !== prev_addr) begin
      addr_log.push_back(ram_addr);
      prev_addr = ram_addr;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected words: walk base + k*stride; past the end either wraps or stops with an error
  task automatic build_model(input int b, input int n, input int s);
    int a;
    exp_q.delete();
    exp_addrs.delete();
    exp_err = 0;
    a = b;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(ram_mem[a]);
      exp_addrs.push_back(AW'(a));
      if (k == n - 1) break;
      a = a + s;
      if (a >= NW) begin
`ifdef DPRAM_STREAM_WRAP_EN
        a = a % NW;
`else
        exp_err = 1;
        break;
`endif
      end
    end
  endtask

  task automatic clear_obs();
    got_q.delete();
    addr_log.delete();
    done_cnt    = 0;
    err_cnt     = 0;
    err_lone    = 0;
    done_cyc    = -1;
    first_valid = -1;
  endtask

  task automatic run_req(input int b, input int n, input int s, input int mode,
                         input bit tchk, input bit achk, input bit poke_en);
    int scyc;
    int t;
    int nexp;
    build_model(b, n, s);
    ready_mode = mode;
    @(posedge clk);
    #1;
    clear_obs();
    start     = 1'b1;
    base_addr = AW'(b);
    count     = (AW+1)'(n);
    stride    = AW'(s);
    scyc      = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    poke  = poke_en;
    check("busy_after_start", {63'd0, busy}, {63'd0, (n != 0)});
    t = 0;
    while (done_cnt == 0 && t < 4000) begin
      @(posedge clk);
      t++;
    end
    poke = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    nexp = exp_q.size();
    check("done_count", done_cnt, 1);
    check("err_with_done", err_cnt, exp_err);
    check("err_without_done", err_lone, 0);
    check("busy_idle", {63'd0, busy}, 64'd0);
    check("word_count", got_q.size(), nexp);
    for (int k = 0; k < nexp && k < got_q.size(); k++) check("word", got_q[k], exp_q[k]);
    if (tchk) begin
      check("done_cycle", done_cyc, (nexp == 0) ? scyc + 1 : scyc + nexp + 3);
      if (nexp > 0) check("first_valid_cycle", first_valid, scyc + 3);
      else check("no_valid", {63'd0, first_valid < 0}, 64'd1);
    end
    if (achk) begin
      check("addr_count", addr_log.size(), exp_addrs.size());
      for (int k = 0; k < exp_addrs.size() && k < addr_log.size(); k++)
        check("ram_addr_seq", addr_log[k], exp_addrs[k]);
      if (exp_addrs.size() > 0) check("ram_addr_hold", ram_addr, exp_addrs[exp_addrs.size()-1]);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    reset      = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    count      = '0;
    stride     = '0;
    out_ready  = 1'b0;
    ready_mode = 0;
    poke       = 1'b0;
    for (int i = 0; i < NW; i++) ram_mem[i] = {DW'($urandom), 28'($urandom)};
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_ram_addr", ram_addr, 64'd0);
    check("rst_ram_wren", {63'd0, ram_wren}, 64'd0);
    check("rst_ram_wdata", ram_wdata, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    reset = 1'b0;

    run_req(12'h010, 4, 1, 0, 1'b1, 1'b1, 1'b0);
    run_req(12'h100, 8, 2, 1, 1'b0, 1'b1, 1'b0);
    run_req(12'h123, 0, 1, 0, 1'b1, 1'b1, 1'b0);
    run_req(12'hFFE, 4, 1, 0, 1'b1, 1'b1, 1'b0);
    run_req(12'h040, 16, 5, 2, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a request that already has data waiting
    build_model(12'h200, 16, 3);
    ready_mode = 1;
    @(posedge clk);
    #1;
    clear_obs();
    start     = 1'b1;
    base_addr = 12'h200;
    count     = 13'd16;
    stride    = 12'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    t = 0;
    while (out_valid !== 1'b1 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("mid_out_valid_seen", {63'd0, out_valid}, 64'd1);
    done_cnt = 0;
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_ram_addr", ram_addr, 64'd0);
    check("mid_rst_out_data", out_data, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("mid_rst_no_done", done_cnt, 0);
    check("mid_rst_idle_valid", {63'd0, out_valid}, 64'd0);
    run_req(12'h300, 5, 7, 0, 1'b1, 1'b1, 1'b0);

    for (int r = 0; r < 12; r++) begin
      int mode;
      mode = $urandom_range(0, 2);
      run_req($urandom_range(0, NW - 1), $urandom_range(1, 40), $urandom_range(0, 300),
              mode, mode == 0, 1'b0, 1'b0);
    end
    run_req(12'hFF0, 4096, 1, 0, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dpram_stream_reader.md
# dpram_stream_reader

Read-side streaming client for the 4096 x 60-bit dual-port RAM. It owns one RAM port and, given a base address, word count and stride, issues one read per cycle while downstream space allows. It returns the words in order on a valid/ready stream. It sits between a tile-buffer RAM and a compute consumer, absorbing the RAM's one-cycle read latency and downstream backpressure with a 3-entry output FIFO.

## Interface
- AWIDTH, 12, RAM address width
- NUM_WORDS, 4096, RAM depth; must equal 2^AWIDTH when wrap is compiled in
- DWIDTH, 60, RAM word width
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle request strobe; ignored while busy=1
- base_addr  in  AWIDTH  first read address, sampled with start
- count  in  AWIDTH+1  words to read, 0..4096, sampled with start
- stride  in  AWIDTH  address increment per word, sampled with start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at end of request
- err  out  1  one-cycle pulse, coincident with done, on a range abort
- ram_addr  out  AWIDTH  RAM port address (registered)
- ram_wren  out  1  constant 0
- ram_wdata  out  DWIDTH  constant 0
- ram_rdata  in  DWIDTH  RAM port read data; valid the cycle after its address is sampled
- out_data  out  DWIDTH  stream data, head of FIFO
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready; a transfer occurs when out_valid & out_ready

## Operation
- The FSM has three states: IDLE, RUN, DRAIN.
- IDLE, start=1, count>0: load addr=base_addr, remaining=count and latched stride; go to RUN.
- IDLE, start=1, count=0: pulse done on the next cycle; stay IDLE; no RAM access.
- RUN issue rule: issue when occ + inflight < 3.
  - occ is the FIFO occupancy (0..3). inflight is 1 if a read was issued in the previous cycle.
  - The rule uses registered terms only, so there is no combinational path from out_ready.
- On each issue:
  - remaining decrements.
  - addr advances to addr+stride, computed at AWIDTH+1 bits.
  - If the issued word is the last one, go to DRAIN.
- Each returning word (inflight=1) is written into the FIFO. The FIFO can never overflow.
- Simultaneous FIFO push and pop keeps occ unchanged.
- DRAIN: when inflight=0 and occ=0, pulse done, clear busy, go to IDLE. done is asserted in the cycle after the last stream transfer.
- A start pulse while busy=1 is dropped; there is no queueing.
- Reset mid-request:
  - The FIFO is emptied and the in-flight read is discarded.
  - No done is pulsed.
  - The state returns to IDLE.
- Reset values:
  - busy, done, err, out_valid, ram_addr, ram_wren and ram_wdata are 0.
  - out_data is 0.

## Timing
- Start sampled at edge E0: ram_addr=base_addr after E0. RAM samples the address at E1. FIFO captures the data at E2. out_valid=1 after E2.
- First-word latency is 3 cycles from start.
- With out_ready held high, the stream sustains 1 word/cycle.
- For N words with no backpressure, done pulses N+3 cycles after start is sampled.
- ram_addr changes only on an issue. The address of the last issue is held until the next request.

## Configuration
- Macro: DPRAM_STREAM_WRAP_EN.
- Defined:
  - The address wraps modulo NUM_WORDS, keeping the low AWIDTH bits.
  - err is never asserted.
- Undefined:
  - If the next address after a non-final issue is ≥ NUM_WORDS, issuing stops and the FSM goes to DRAIN.
  - Words already issued are still delivered.
  - err and done then pulse together.

## Structure
- Package dpram_stream_pkg holds:
  - the AWIDTH, DWIDTH and NUM_WORDS defaults;
  - the FSM state enum (IDLE, RUN, DRAIN);
  - FIFO_DEPTH=3.
- Sub-module dpram_rd_fifo: a 3-entry synchronous FIFO.
  - Ports: push/pop, full/empty and occupancy output.
  - Async active-high reset on clk/reset.
  - Its head register drives out_data.

## Test plan
- base=0x010, count=4, stride=1, out_ready=1 → RAM addresses 0x010..0x013 on consecutive cycles. out_valid high cycles 3-6 with words in order. done at cycle 7.
- base=0x100, count=8, stride=2, out_ready toggling 1/0 → all 8 words delivered in order with no duplicates or losses. occ never exceeds 3.
- count=0 → no ram_addr change, out_valid stays 0, done pulses 1 cycle after start.
- base=0xFFE, count=4, stride=1:
  - with DPRAM_STREAM_WRAP_EN: addresses 0xFFE, 0xFFF, 0x000, 0x001; err=0.
  - without it: 2 words delivered, then done and err pulse together.
- start pulsed again during a busy 16-word request → ignored. Exactly 16 words and one done.
- reset asserted mid-request with out_valid=1 → out_valid, busy and ram_addr are 0 immediately. No done. A new start after reset runs normally.
